// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Purpose:
//   Bridges the 32-bit CPU peripheral bus to the accelerator datapath. The CPU
//   fills a 256-slot x 64-bit instruction memory with pairs of 32-bit writes
//   (low half at even address, high half at odd address), then writes the
//   control register at 0x1FF to start. The sequencer walks the memory from
//   slot 0, presenting each instruction on a valid/ready handshake, and stops
//   after the END opcode or slot 254, raising a level completion interrupt.
//
// Ports:
//   clk                    system clock, rising edge
//   rst_n                  synchronous active-low reset
//   CPU_instruction_valid  bus write strobe (one write per cycle)
//   CPU_instruction_addr   bus write address, INSTR_NUM_BIT+1 bits
//   CPU_instruction_data   bus write data
//   CPU_instruction_irq    completion interrupt (level)
//   instr_out_valid        instruction available to the datapath
//   instr_out_ready        datapath accepts the instruction
//   instr_out_data         instruction word
//   instr_out_pc           slot index of instr_out_data
//   busy                   high while a program is being sequenced
//
// Control register (0x1FF): data[0]=start, data[1]=abort, data[2]=irq clear.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int              INSTR_NUM_BIT = 8,
  parameter int              INSTR_WIDTH   = 64,
  parameter int              BUS_WIDTH     = 32,
  parameter logic [3:0]      END_OPCODE    = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     CPU_instruction_valid,
  input  logic [INSTR_NUM_BIT:0]   CPU_instruction_addr,
  input  logic [BUS_WIDTH-1:0]     CPU_instruction_data,
  output logic                     CPU_instruction_irq,
  output logic                     instr_out_valid,
  input  logic                     instr_out_ready,
  output logic [INSTR_WIDTH-1:0]   instr_out_data,
  output logic [INSTR_NUM_BIT-1:0] instr_out_pc,
  output logic                     busy
);

  localparam int DEPTH = 1 << INSTR_NUM_BIT;

  // Top address is the control register, the one below it is a hole.
  localparam logic [INSTR_NUM_BIT:0]   CTRL_ADDR = '1;
  localparam logic [INSTR_NUM_BIT:0]   HOLE_ADDR = CTRL_ADDR - 1'b1;
  // Last executable slot; the slot above it shadows the control address.
  localparam logic [INSTR_NUM_BIT-1:0] LAST_PC   = INSTR_NUM_BIT'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [INSTR_NUM_BIT-1:0] pc_reg, pc_next;
  logic                     valid_reg, valid_next;
  logic [INSTR_WIDTH-1:0]   data_reg, data_next;
  logic [INSTR_NUM_BIT-1:0] out_pc_reg, out_pc_next;
  logic                     irq_reg, irq_next;

  logic                     idle_like;
  logic                     ctrl_hit;
  logic                     cmd_start;
  logic                     cmd_abort;
  logic                     cmd_clear;
  logic                     mem_we;
  logic [INSTR_NUM_BIT-1:0] wr_slot;
  logic                     wr_half;
  logic                     handshake;
  logic                     is_last;
  logic                     rd_en;
  logic [INSTR_NUM_BIT-1:0] rd_addr;
  logic [INSTR_WIDTH-1:0]   rd_data;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign idle_like = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign ctrl_hit  = CPU_instruction_valid && (CPU_instruction_addr == CTRL_ADDR);
  assign cmd_start = ctrl_hit && CPU_instruction_data[0];
  assign cmd_abort = ctrl_hit && CPU_instruction_data[1];
  assign cmd_clear = ctrl_hit && CPU_instruction_data[2];

  // Program memory is only writable while nothing is being sequenced, so the
  // read port never sees a write to the slot it is fetching.
  assign mem_we  = rst_n && CPU_instruction_valid && idle_like &&
                   (CPU_instruction_addr < HOLE_ADDR);
  assign wr_slot = CPU_instruction_addr[INSTR_NUM_BIT:1];
  assign wr_half = CPU_instruction_addr[0];

  // ---------------------------------------------------------------------------
  // Instruction memory: one 32-bit array per half so each bus write touches
  // only its own half. Registered read, separate read and write ports.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      logic [BUS_WIDTH-1:0] mem [DEPTH];
      logic [BUS_WIDTH-1:0] rd_half_reg;

      always_ff @(posedge clk) begin
        if (mem_we && (wr_half == 1'(gi))) begin
          mem[wr_slot] <= CPU_instruction_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rd_en) begin
          rd_half_reg <= mem[rd_addr];
        end
      end

      assign rd_data[gi*BUS_WIDTH +: BUS_WIDTH] = rd_half_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  assign handshake = (state_reg == S_ISSUE) && instr_out_ready;
  assign is_last   = (data_reg[INSTR_WIDTH-1 -: 4] == END_OPCODE) || (pc_reg == LAST_PC);

  // The read is launched on the edge that enters WAIT, addressed by the pc
  // that WAIT will use. After the first instruction the handshake edge itself
  // launches the read of pc+1 and goes straight to WAIT, which is what gives
  // one instruction every two cycles with ready held high.
  assign rd_en   = (state_next == S_WAIT);
  assign rd_addr = pc_next;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    valid_next  = valid_reg;
    data_next   = data_reg;
    out_pc_next = out_pc_reg;
    irq_next    = irq_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (cmd_start) begin
          state_next = S_FETCH;
          pc_next    = '0;
          irq_next   = 1'b0;
        end
      end
      S_FETCH: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        data_next   = rd_data;
        out_pc_next = pc_reg;
        valid_next  = 1'b1;
        state_next  = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          valid_next = 1'b0;
          if (is_last) begin
            irq_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything above, including a start in the same write.
    // The interrupt keeps whatever value it had.
    if (cmd_abort) begin
      state_next  = S_IDLE;
      valid_next  = 1'b0;
      pc_next     = '0;
      out_pc_next = '0;
      irq_next    = irq_reg;
    end

    // Clear wins even over an interrupt that would rise this cycle.
    if (cmd_clear) begin
      irq_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      out_pc_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      valid_reg  <= valid_next;
      data_reg   <= data_next;
      out_pc_reg <= out_pc_next;
      irq_reg    <= irq_next;
    end
  end

  assign CPU_instruction_irq = irq_reg;
  assign instr_out_valid     = valid_reg;
  assign instr_out_data      = data_reg;
  assign instr_out_pc        = out_pc_reg;
  assign busy                = !((state_reg == S_IDLE) || (state_reg == S_DONE));

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. Expected instructions are pushed to a
// scoreboard queue from a reference copy of the program when a run is started
// and popped as the datapath side accepts them. Issue timing, stall stability,
// interrupt behaviour, abort, bus-write lockout and mid-run reset are checked.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        CPU_instruction_valid;
  logic [8:0]  CPU_instruction_addr;
  logic [31:0] CPU_instruction_data;
  logic        CPU_instruction_irq;
  logic        instr_out_valid;
  logic        instr_out_ready;
  logic [63:0] instr_out_data;
  logic [7:0]  instr_out_pc;
  logic        busy;

  instr_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .CPU_instruction_valid (CPU_instruction_valid),
    .CPU_instruction_addr  (CPU_instruction_addr),
    .CPU_instruction_data  (CPU_instruction_data),
    .CPU_instruction_irq   (CPU_instruction_irq),
    .instr_out_valid       (instr_out_valid),
    .instr_out_ready       (instr_out_ready),
    .instr_out_data        (instr_out_data),
    .instr_out_pc          (instr_out_pc),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] model_mem [256];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; bus strobes last one edge.
  task automatic step();
    @(posedge clk);
    #1;
    CPU_instruction_valid = 1'b0;
  endtask

  task automatic drive_bus(input logic [8:0] addr, input logic [31:0] data);
    CPU_instruction_valid = 1'b1;
    CPU_instruction_addr  = addr;
    CPU_instruction_data  = data;
  endtask

  task automatic bus_write(input logic [8:0] addr, input logic [31:0] data);
    drive_bus(addr, data);
    step();
  endtask

  task automatic write_slot(input int slot, input logic [63:0] value);
    bus_write({8'(slot), 1'b0}, value[31:0]);
    bus_write({8'(slot), 1'b1}, value[63:32]);
    model_mem[slot] = value;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_irq"},   64'(CPU_instruction_irq), 64'd0);
    chk({tag, "_valid"}, 64'(instr_out_valid),     64'd0);
    chk({tag, "_data"},  instr_out_data,           64'd0);
    chk({tag, "_pc"},    64'(instr_out_pc),        64'd0);
    chk({tag, "_busy"},  64'(busy),                64'd0);
  endtask

  // Start the program and follow it cycle by cycle. Cycle 0 is the cycle
  // right after the edge that sampled the start write.
  task automatic run_program(input int stall_pc, input int stall_len, input bit inject,
                             input int abort_pc, input int reset_pc);
    exp_t        e;
    int          cyc;
    int          next_valid;
    int          stall_cnt;
    bit          prev_valid;
    bit          done;
    bit          last;
    bit          stalled;
    logic [63:0] held_data;
    logic [7:0]  held_pc;

    exp_q.delete();
    for (int p = 0; p < 255; p++) begin
      e.pc   = 8'(p);
      e.data = model_mem[p];
      exp_q.push_back(e);
      if (model_mem[p][63:60] == 4'hF) break;
    end

    instr_out_ready = 1'b1;
    bus_write(9'h1FF, 32'd1);
    cyc = 0; next_valid = 2; stall_cnt = 0; prev_valid = 1'b0;
    done = 1'b0; last = 1'b0; stalled = 1'b0;
    held_data = '0; held_pc = '0;

    while (!done && cyc < 3000) begin
      if (last) begin
        chk("irq_after_last", 64'(CPU_instruction_irq), 64'd1);
        chk("busy_after_last", 64'(busy), 64'd0);
        chk("valid_after_last", 64'(instr_out_valid), 64'd0);
        done = 1'b1;
      end else begin
        if (stalled) chk("valid_held", 64'(instr_out_valid), 64'd1);
        stalled = 1'b0;
        if (instr_out_valid) begin
          if (!prev_valid) chk("valid_timing", 64'(cyc), 64'(next_valid));
          if (int'(instr_out_pc) == abort_pc) begin
            instr_out_ready = 1'b0;
            drive_bus(9'h1FF, 32'd2);
            step();
            chk("abort_valid", 64'(instr_out_valid), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_irq", 64'(CPU_instruction_irq), 64'd0);
            $display("abort at pc=%0d", abort_pc);
            exp_q.delete();
            done = 1'b1;
          end else if (int'(instr_out_pc) == reset_pc) begin
            rst_n = 1'b0;
            step();
            check_reset_outputs("midrun_reset");
            $display("reset at pc=%0d", reset_pc);
            rst_n = 1'b1;
            exp_q.delete();
            done = 1'b1;
          end else if (int'(instr_out_pc) == stall_pc && stall_cnt < stall_len) begin
            if (stall_cnt == 0) begin
              held_data = instr_out_data;
              held_pc   = instr_out_pc;
            end else begin
              chk("stall_data", instr_out_data, held_data);
              chk("stall_pc", 64'(instr_out_pc), 64'(held_pc));
            end
            stall_cnt++;
            stalled = 1'b1;
            instr_out_ready = 1'b0;
          end else begin
            instr_out_ready = 1'b1;
            if (exp_q.size() == 0) begin
              chk("unexpected_issue", 64'd1, 64'd0);
              done = 1'b1;
            end else begin
              e = exp_q.pop_front();
              chk("issue_data", instr_out_data, e.data);
              chk("issue_pc", 64'(instr_out_pc), 64'(e.pc));
              $display("handshake pc=%0d data=0x%016h", instr_out_pc, instr_out_data);
              next_valid = cyc + 2;
              if (exp_q.size() == 0) last = 1'b1;
            end
          end
        end else begin
          instr_out_ready = 1'b1;
        end
        prev_valid = instr_out_valid;
        if (inject && cyc == 3) drive_bus(9'h004, 32'hDEAD_BEEF);
        if (inject && cyc == 5) drive_bus(9'h1FF, 32'd1);
      end
      if (!done) begin
        step();
        cyc++;
      end
    end
    if (!done) chk("run_timeout", 64'd0, 64'd1);
    instr_out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                 = 1'b0;
    CPU_instruction_valid = 1'b0;
    CPU_instruction_addr  = '0;
    CPU_instruction_data  = '0;
    instr_out_ready       = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;

    // 1: reset held with bus noise
    for (int i = 0; i < 3; i++) begin
      drive_bus(9'($urandom_range(0, 511)), $urandom);
      step();
      check_reset_outputs("reset_hold");
    end
    rst_n = 1'b1;
    step();

    // 2: three-instruction program, ready high
    write_slot(0, 64'h0000_0001_0000_0002);
    write_slot(1, 64'h1234_5678_9ABC_DEF0);
    write_slot(2, 64'hF000_0000_0000_0000);
    run_program(-1, 0, 1'b0, -1, -1);

    // 3: back-pressure for five cycles on pc 1
    run_program(1, 5, 1'b0, -1, -1);

    // 4: bus writes and start while busy are dropped; rerun sees original slot 2
    run_program(-1, 0, 1'b1, -1, -1);
    run_program(-1, 0, 1'b0, -1, -1);

    // 5: abort, start+abort, irq clear after DONE
    run_program(-1, 0, 1'b0, 1, -1);
    bus_write(9'h1FF, 32'd3);
    step();
    step();
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_valid", 64'(instr_out_valid), 64'd0);
    run_program(-1, 0, 1'b0, -1, -1);
    bus_write(9'h1FF, 32'd4);
    chk("irq_clear", 64'(CPU_instruction_irq), 64'd0);
    chk("irq_clear_busy", 64'(busy), 64'd0);

    // 6: full memory with no END opcode, then a reset mid-run
    for (int s = 0; s < 255; s++) begin
      write_slot(s, {$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF);
    end
    run_program(-1, 0, 1'b0, -1, -1);
    run_program(-1, 0, 1'b0, -1, 10);
    step();
    check_reset_outputs("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
